// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Types and constants shared by the memory port arbiter and its winner-select
// helper.
//   arb_state_e : arbiter FSM state (idle / one access outstanding)
//   arb_owner_e : which requester owns the outstanding access
//   MSZ_*       : access size encoding, identical to the CPU store-size field
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

    localparam logic [1:0] MSZ_NONE = 2'b00;
    localparam logic [1:0] MSZ_B    = 2'b01;
    localparam logic [1:0] MSZ_H    = 2'b10;
    localparam logic [1:0] MSZ_W    = 2'b11;

    // A data request carrying size 00 describes no access and must never win.
    function automatic logic size_is_access(input logic [1:0] size);
        return (size != MSZ_NONE);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// ----------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner select between the fetch and data requesters.
// Ports:
//   if_req      in  fetch request present
//   d_req       in  data request present (already qualified by size)
//   eligible    in  the arbiter may issue an access this cycle
//   streak_full in  data has won MAX_D_STREAK times in a row while fetch waited
//   if_win      out fetch is granted this cycle
//   d_win       out data is granted this cycle
// At most one of if_win / d_win is ever high.
// ----------------------------------------------------------------------------
module mem_arb_pick (
    input  logic if_req,
    input  logic d_req,
    input  logic eligible,
    input  logic streak_full,
    output logic if_win,
    output logic d_win
);

    // Data has priority unless fetch has been starved for a full streak.
    always_comb begin
        if_win = 1'b0;
        d_win  = 1'b0;
        if (eligible) begin
            if (d_req && !(if_req && streak_full)) begin
                d_win = 1'b1;
            end else if (if_req) begin
                if_win = 1'b1;
            end else begin
                if_win = 1'b0;
                d_win  = 1'b0;
            end
        end else begin
            if_win = 1'b0;
            d_win  = 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port, fixed-latency memory between the CPU fetch port and
// data port. Accesses are serialised; read data is steered back to whichever
// requester issued the access.
// Parameters:
//   MEM_LAT      cycles from o_m_en to i_m_rdata valid (>=1)
//   MAX_D_STREAK max consecutive data grants while fetch waits (>=1)
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_if_req/i_if_addr             fetch request and word address
//   o_if_gnt/o_if_valid/o_if_rdata fetch accept (comb), completion pulse, data
//   i_d_req/i_d_we/i_d_size/
//   i_d_addr/i_d_wdata             data request and its attributes
//   o_d_gnt/o_d_valid/o_d_rdata    data accept (comb), completion pulse, data
//   o_m_en/o_m_we/o_m_size/
//   o_m_addr/o_m_wdata             memory command, all zero when o_m_en=0
//   i_m_rdata                      memory read data, MEM_LAT cycles after o_m_en
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT      = 1,
    parameter int MAX_D_STREAK = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_valid,
    output logic [31:0] o_if_rdata,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [1:0]  i_d_size,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic        o_d_gnt,
    output logic        o_d_valid,
    output logic [31:0] o_d_rdata,
    output logic        o_m_en,
    output logic        o_m_we,
    output logic [1:0]  o_m_size,
    output logic [31:0] o_m_addr,
    output logic [31:0] o_m_wdata,
    input  logic [31:0] i_m_rdata
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int STR_W = $clog2(MAX_D_STREAK + 1);

    localparam logic [LAT_W-1:0] LAT_ZERO = LAT_W'(0);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
    localparam logic [STR_W-1:0] STR_ZERO = STR_W'(0);
    localparam logic [STR_W-1:0] STR_ONE  = STR_W'(1);
    localparam logic [STR_W-1:0] STR_MAX  = STR_W'(MAX_D_STREAK);

    arb_state_e       state_r,    state_s;
    arb_owner_e       owner_r,    owner_s;
    logic             owner_we_r, owner_we_s;
    logic [LAT_W-1:0] lat_cnt_r,  lat_cnt_s;
    logic [STR_W-1:0] d_streak_r, d_streak_s;

    logic eligible_s;
    logic done_s;
    logic d_req_ok_s;
    logic streak_full_s;
    logic if_win_s;
    logic d_win_s;

    // Issue window and completion both occur on the last latency cycle, which
    // is what allows back-to-back issue; reset masks both.
    always_comb begin
        eligible_s    = 1'b0;
        done_s        = 1'b0;
        d_req_ok_s    = i_d_req && size_is_access(i_d_size);
        streak_full_s = (d_streak_r == STR_MAX);
        if (i_rst) begin
            eligible_s = 1'b0;
            done_s     = 1'b0;
        end else begin
            eligible_s = (state_r == ARB_IDLE) || (lat_cnt_r == LAT_ONE);
            done_s     = (state_r == ARB_BUSY) && (lat_cnt_r == LAT_ONE);
        end
    end

    mem_arb_pick u_pick (
        .if_req      (i_if_req),
        .d_req       (d_req_ok_s),
        .eligible    (eligible_s),
        .streak_full (streak_full_s),
        .if_win      (if_win_s),
        .d_win       (d_win_s)
    );

    // Next-state logic: latency countdown, then a fresh grant overrides it.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        owner_we_s = owner_we_r;
        lat_cnt_s  = lat_cnt_r;
        case (state_r)
            ARB_IDLE: begin
                lat_cnt_s = LAT_ZERO;
            end
            ARB_BUSY: begin
                if (lat_cnt_r == LAT_ONE) begin
                    state_s   = ARB_IDLE;
                    lat_cnt_s = LAT_ZERO;
                end else begin
                    lat_cnt_s = lat_cnt_r - LAT_ONE;
                end
            end
            default: begin
                state_s   = ARB_IDLE;
                lat_cnt_s = LAT_ZERO;
            end
        endcase
        if (if_win_s || d_win_s) begin
            state_s    = ARB_BUSY;
            lat_cnt_s  = LAT_LOAD;
            owner_s    = d_win_s ? OWN_D : OWN_IF;
            owner_we_s = d_win_s && i_d_we;
        end else begin
            owner_s    = owner_r;
            owner_we_s = owner_we_r;
        end
    end

    // Data streak: any cycle without a waiting fetch, or a fetch grant, clears it.
    always_comb begin
        d_streak_s = d_streak_r;
        if (!i_if_req || if_win_s) begin
            d_streak_s = STR_ZERO;
        end else if (d_win_s && !streak_full_s) begin
            d_streak_s = d_streak_r + STR_ONE;
        end else begin
            d_streak_s = d_streak_r;
        end
    end

    // State registers with synchronous reset; reset drops any outstanding access.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ARB_IDLE;
            owner_r    <= OWN_IF;
            owner_we_r <= 1'b0;
            lat_cnt_r  <= LAT_ZERO;
            d_streak_r <= STR_ZERO;
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            owner_we_r <= owner_we_s;
            lat_cnt_r  <= lat_cnt_s;
            d_streak_r <= d_streak_s;
        end
    end

    // Memory command is driven in the grant cycle and held at zero otherwise.
    always_comb begin
        o_if_gnt  = if_win_s;
        o_d_gnt   = d_win_s;
        o_m_en    = 1'b0;
        o_m_we    = 1'b0;
        o_m_size  = MSZ_NONE;
        o_m_addr  = 32'h0000_0000;
        o_m_wdata = 32'h0000_0000;
        if (d_win_s) begin
            o_m_en    = 1'b1;
            o_m_we    = i_d_we;
            o_m_size  = i_d_size;
            o_m_addr  = i_d_addr;
            o_m_wdata = i_d_we ? i_d_wdata : 32'h0000_0000;
        end else if (if_win_s) begin
            o_m_en    = 1'b1;
            o_m_we    = 1'b0;
            o_m_size  = MSZ_W;
            o_m_addr  = i_if_addr;
            o_m_wdata = 32'h0000_0000;
        end else begin
            o_m_en    = 1'b0;
        end
    end

    // Completion steering: rdata is forced to zero outside the valid pulse and
    // for store completions.
    always_comb begin
        o_if_valid = 1'b0;
        o_if_rdata = 32'h0000_0000;
        o_d_valid  = 1'b0;
        o_d_rdata  = 32'h0000_0000;
        if (done_s && (owner_r == OWN_IF)) begin
            o_if_valid = 1'b1;
            o_if_rdata = i_m_rdata;
        end else if (done_s && (owner_r == OWN_D)) begin
            o_d_valid  = 1'b1;
            o_d_rdata  = owner_we_r ? 32'h0000_0000 : i_m_rdata;
        end else begin
            o_if_valid = 1'b0;
            o_d_valid  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Two arbiter instances share one clock: index 0 with MEM_LAT=1, index 1 with
// MEM_LAT=3. A memory model returns a pattern derived from the address.
// Grants push expected completions (due cycle + data) onto a scoreboard; the
// negedge monitor pops them when a valid pulse appears.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    typedef struct {
        int          g;
        bit          is_d;
        int          due;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic        if_req   [2];
    logic [31:0] if_addr  [2];
    logic        if_gnt   [2];
    logic        if_valid [2];
    logic [31:0] if_rdata [2];
    logic        d_req    [2];
    logic        d_we     [2];
    logic [1:0]  d_size   [2];
    logic [31:0] d_addr   [2];
    logic [31:0] d_wdata  [2];
    logic        d_gnt    [2];
    logic        d_valid  [2];
    logic [31:0] d_rdata  [2];
    logic        m_en     [2];
    logic        m_we     [2];
    logic [1:0]  m_size   [2];
    logic [31:0] m_addr   [2];
    logic [31:0] m_wdata  [2];
    logic [31:0] m_rdata  [2];

    logic [31:0] pipe0;
    logic [31:0] pipe1 [3];

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_dut
            mem_port_arbiter #(
                .MEM_LAT      ((gi == 0) ? 1 : 3),
                .MAX_D_STREAK (4)
            ) u_dut (
                .i_clk      (clk),
                .i_rst      (rst[gi]),
                .i_if_req   (if_req[gi]),
                .i_if_addr  (if_addr[gi]),
                .o_if_gnt   (if_gnt[gi]),
                .o_if_valid (if_valid[gi]),
                .o_if_rdata (if_rdata[gi]),
                .i_d_req    (d_req[gi]),
                .i_d_we     (d_we[gi]),
                .i_d_size   (d_size[gi]),
                .i_d_addr   (d_addr[gi]),
                .i_d_wdata  (d_wdata[gi]),
                .o_d_gnt    (d_gnt[gi]),
                .o_d_valid  (d_valid[gi]),
                .o_d_rdata  (d_rdata[gi]),
                .o_m_en     (m_en[gi]),
                .o_m_we     (m_we[gi]),
                .o_m_size   (m_size[gi]),
                .o_m_addr   (m_addr[gi]),
                .o_m_wdata  (m_wdata[gi]),
                .i_m_rdata  (m_rdata[gi])
            );
        end
    endgenerate

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    // Memory model: address pipeline of the instance's latency.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        pipe0    <= m_addr[0];
        pipe1[0] <= m_addr[1];
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign m_rdata[0] = memf(pipe0);
    assign m_rdata[1] = memf(pipe1[2]);

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Pop the oldest expected completion of (g, kind) and compare it.
    task automatic match_valid(input int g, input bit is_d, input logic [31:0] rdata);
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].g == g && sb[i].is_d == is_d) idx = i;
        end
        if (idx < 0) begin
            check_val(is_d ? "d_unexp_valid" : "if_unexp_valid", is_d ? d_valid[g] : if_valid[g], 1'b0);
        end else begin
            check_val(is_d ? "d_valid_cycle" : "if_valid_cycle", cyc, sb[idx].due);
            check_val(is_d ? "d_rdata" : "if_rdata", rdata, sb[idx].data);
            sb.delete(idx);
        end
    endtask

    // Monitor: command-port checks, scoreboard push on grant, pop on valid.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst[g]) begin
                check_val("rst_gnt", {if_gnt[g], d_gnt[g]}, 2'b00);
                check_val("rst_valid", {if_valid[g], d_valid[g]}, 2'b00);
                check_val("rst_m_en", m_en[g], 1'b0);
                for (int i = sb.size() - 1; i >= 0; i--) begin
                    if (sb[i].g == g) sb.delete(i);
                end
            end else begin
                if (if_valid[g]) match_valid(g, 1'b0, if_rdata[g]);
                else check_val("if_rdata_idle", if_rdata[g], 32'h0);
                if (d_valid[g]) match_valid(g, 1'b1, d_rdata[g]);
                else check_val("d_rdata_idle", d_rdata[g], 32'h0);
                check_val("one_gnt", if_gnt[g] & d_gnt[g], 1'b0);
                if (d_gnt[g]) begin
                    check_val("d_m_en", m_en[g], 1'b1);
                    check_val("d_m_we", m_we[g], d_we[g]);
                    check_val("d_m_size", m_size[g], d_size[g]);
                    check_val("d_m_addr", m_addr[g], d_addr[g]);
                    if (d_we[g]) check_val("d_m_wdata", m_wdata[g], d_wdata[g]);
                    sb.push_back('{g, 1'b1, cyc + lat_of(g), d_we[g] ? 32'h0 : memf(d_addr[g])});
                end else if (if_gnt[g]) begin
                    check_val("if_m_en", m_en[g], 1'b1);
                    check_val("if_m_we", m_we[g], 1'b0);
                    check_val("if_m_size", m_size[g], 2'b11);
                    check_val("if_m_addr", m_addr[g], if_addr[g]);
                    sb.push_back('{g, 1'b0, cyc + lat_of(g), memf(if_addr[g])});
                end else begin
                    check_val("idle_m_en", m_en[g], 1'b0);
                    check_val("idle_m_cmd", {m_we[g], m_size[g], m_addr[g]}, 35'h0);
                    check_val("idle_m_wdata", m_wdata[g], 32'h0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input int g, input logic [31:0] a, output int gcyc);
        bit ok;
        ok      = 1'b0;
        gcyc    = -1;
        if_req[g]  = 1'b1;
        if_addr[g] = a;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (if_gnt[g]) begin
                ok   = 1'b1;
                gcyc = cyc;
            end else begin
                tick();
            end
        end
        check_val("fetch_gnt_seen", if_gnt[g], 1'b1);
        tick();
        if_req[g] = 1'b0;
    endtask

    task automatic do_data(input int g, input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd, output int gcyc);
        bit ok;
        ok      = 1'b0;
        gcyc    = -1;
        d_req[g]   = 1'b1;
        d_we[g]    = we;
        d_size[g]  = sz;
        d_addr[g]  = a;
        d_wdata[g] = wd;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (d_gnt[g]) begin
                ok   = 1'b1;
                gcyc = cyc;
            end else begin
                tick();
            end
        end
        check_val("data_gnt_seen", d_gnt[g], 1'b1);
        tick();
        d_req[g] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int c0, c1, c2;
        for (int g = 0; g < 2; g++) begin
            rst[g]     = 1'b1;
            if_req[g]  = 1'b0;
            if_addr[g] = 32'h0;
            d_req[g]   = 1'b0;
            d_we[g]    = 1'b0;
            d_size[g]  = 2'b00;
            d_addr[g]  = 32'h0;
            d_wdata[g] = 32'h0;
        end
        repeat (3) tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Reset state: nothing granted, nothing valid, memory port quiet.
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check_val("reset_gnt", {if_gnt[g], d_gnt[g]}, 2'b00);
            check_val("reset_valid", {if_valid[g], d_valid[g]}, 2'b00);
            check_val("reset_m_en", m_en[g], 1'b0);
        end
        tick();

        // 1: fetch-only stream at MEM_LAT=1, granted every cycle.
        do_fetch(0, 32'h0000_0000, c0);
        do_fetch(0, 32'h0000_0004, c1);
        do_fetch(0, 32'h0000_0008, c2);
        check_val("t1_b2b_a", c1 - c0, 1);
        check_val("t1_b2b_b", c2 - c1, 1);
        repeat (2) tick();

        // 4: byte store, completion carries zero data.
        do_data(0, 1'b1, 2'b01, 32'h0000_0020, 32'hDEAD_BEEF, c0);
        repeat (2) tick();

        // 3: both requesting continuously -> D,D,D,D,IF repeating.
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h0000_0300;
        d_req[0]   = 1'b1;
        d_we[0]    = 1'b0;
        d_size[0]  = 2'b11;
        d_addr[0]  = 32'h0000_0200;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check_val("t3_order", {if_gnt[0], d_gnt[0]}, ((k % 5) == 4) ? 2'b10 : 2'b01);
            tick();
        end
        if_req[0] = 1'b0;
        d_req[0]  = 1'b0;
        repeat (2) tick();

        // 6: data request with size 00 is never granted; fetch proceeds.
        d_req[0]   = 1'b1;
        d_size[0]  = 2'b00;
        d_addr[0]  = 32'h0000_0050;
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h0000_0060;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("t6_if_gnt", if_gnt[0], 1'b1);
            check_val("t6_d_gnt", d_gnt[0], 1'b0);
            tick();
        end
        d_req[0]  = 1'b0;
        if_req[0] = 1'b0;
        repeat (2) tick();

        // 2: MEM_LAT=3 half load; fetch raised one cycle later waits until cycle 3.
        d_req[1]  = 1'b1;
        d_we[1]   = 1'b0;
        d_size[1] = 2'b10;
        d_addr[1] = 32'h0000_0100;
        @(negedge clk);
        check_val("t2_d_gnt_c0", d_gnt[1], 1'b1);
        tick();
        d_req[1]   = 1'b0;
        if_req[1]  = 1'b1;
        if_addr[1] = 32'h0000_0040;
        @(negedge clk);
        check_val("t2_if_gnt_c1", if_gnt[1], 1'b0);
        tick();
        @(negedge clk);
        check_val("t2_if_gnt_c2", if_gnt[1], 1'b0);
        tick();
        @(negedge clk);
        check_val("t2_if_gnt_c3", if_gnt[1], 1'b1);
        check_val("t2_d_valid_c3", d_valid[1], 1'b1);
        tick();
        if_req[1] = 1'b0;
        repeat (5) tick();

        // 5: reset one cycle after a grant drops the access; next request
        // is granted in the first cycle after reset falls.
        d_req[1]  = 1'b1;
        d_we[1]   = 1'b0;
        d_size[1] = 2'b11;
        d_addr[1] = 32'h0000_0180;
        @(negedge clk);
        check_val("t5_d_gnt", d_gnt[1], 1'b1);
        tick();
        d_req[1]   = 1'b0;
        rst[1]     = 1'b1;
        if_req[1]  = 1'b1;
        if_addr[1] = 32'h0000_0044;
        @(negedge clk);
        check_val("t5_rst_if_gnt", if_gnt[1], 1'b0);
        check_val("t5_rst_m_en", m_en[1], 1'b0);
        tick();
        rst[1] = 1'b0;
        @(negedge clk);
        check_val("t5_post_rst_gnt", if_gnt[1], 1'b1);
        tick();
        if_req[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("t5_no_d_valid", d_valid[1], 1'b0);
            tick();
        end

        repeat (4) tick();
        check_val("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
